// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and default frame geometry,
// used by the receive sequencer, the stop-bit checker and the transmitter.
package uart_pkg;

    localparam int UART_OSR       = 16;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_tick_counter.sv
// Oversample-tick counter: advances modulo OSR only on baud_tick, with
// decodes for the half-bit and full-bit points.
module uart_tick_counter #(
    parameter int OSR = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   baud_tick_i,
    input  logic                   clear_i,
    output logic [$clog2(OSR)-1:0] cnt_o,
    output logic                   half_o,
    output logic                   full_o
);

    localparam int CW = $clog2(OSR);

    logic [CW-1:0] cnt_q;

    // Count ticks; clear takes effect only on a tick so timing stays tick-aligned.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (baud_tick_i) begin
            if (clear_i) cnt_q <= '0;
            else         cnt_q <= cnt_q + CW'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign half_o = (cnt_q == CW'(OSR/2 - 1));
    assign full_o = (cnt_q == CW'(OSR - 1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit validation, mid-bit data sampling,
// stop-window handoff to the stop-bit checker, and a single-entry
// valid/ready output register with overrun flagging.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OSR       = UART_OSR,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baud_tick_i,
    input  logic                 rx_in_i,
    input  logic                 stop_err_i,
    output logic                 check_stop_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic [DATA_BITS-1:0] rx_byte_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(OSR);
    localparam int BW = $clog2(DATA_BITS) + 1;

    rx_state_t            state_q,     state_d;
    logic [BW-1:0]        bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic [DATA_BITS-1:0] rx_byte_q,   rx_byte_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;

    logic          cnt_clr;
    logic [CW-1:0] cnt;
    logic          half;
    logic          full;
    logic          deliver;

    uart_tick_counter #(
        .OSR (OSR)
    ) u_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .baud_tick_i (baud_tick_i),
        .clear_i     (cnt_clr),
        .cnt_o       (cnt),
        .half_o      (half),
        .full_o      (full)
    );

    // State, shift register and output-register flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            rx_data_q   <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            rx_data_q   <= rx_data_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Frame sequencing: every transition is qualified by baud_tick, so the
    // FSM and counters hold while ticks are absent.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        rx_data_d   = rx_data_q;
        cnt_clr     = 1'b0;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Counter is held at zero so START begins counting from 0.
                cnt_clr = 1'b1;
                if (baud_tick_i && !rx_in_i) state_d = START;
            end
            START: begin
                if (baud_tick_i && half) begin
                    cnt_clr = 1'b1;
                    if (!rx_in_i) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Line went back high before mid-start: glitch.
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                // Counter wraps to 0 by itself after full.
                if (baud_tick_i && full) begin
                    rx_data_d = {rx_in_i, rx_data_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + BW'(1);
                    if (bit_idx_q == BW'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (baud_tick_i && full) begin
                    state_d = IDLE;
                    if (rx_in_i && !stop_err_i) deliver     = 1'b1;
                    else                        frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: accept clears valid; a delivery loads it when empty
    // or being drained this cycle, otherwise the new byte is dropped.
    always_comb begin
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
        if (deliver) begin
            if (!rx_valid_q || rx_ready_i) begin
                rx_byte_d  = rx_data_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign check_stop_o = (state_q == STOP);
    assign busy_o       = (state_q != IDLE);
    assign rx_data_o    = rx_data_q;
    assign rx_byte_o    = rx_byte_q;
    assign rx_valid_o   = rx_valid_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive sequencer for the 16x-oversampled receive path. Detects and validates the start bit, samples 8 data bits at mid-bit, and drives `check_stop` and `rx_data` into the stop-bit checker for the stop window. It then combines its own stop sample with the checker's `stop_err`. Accepted bytes go to the host through a single-entry valid/ready output register with overrun flagging.

## Interface
- `OSR`, 16: oversample ticks per bit; power of two, ≥4.
- `DATA_BITS`, 8: data bits per frame, LSB first.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `baud_tick`  in  1  one-`clk` pulse at OSR × baud; all bit timing advances only on this.
- `rx_in`  in  1  serial line, already synchronized to `clk`; idle high.
- `stop_err`  in  1  stop-bit checker error, sampled in STOP.
- `check_stop`  out  1  high for the whole STOP state.
- `rx_data`  out  DATA_BITS  shift register contents; valid and stable throughout STOP.
- `rx_byte`  out  DATA_BITS  accepted byte; held while `rx_valid`.
- `rx_valid`  out  1  `rx_byte` available.
- `rx_ready`  in  1  host accepts `rx_byte` when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-`clk` pulse: bad stop bit; byte discarded.
- `overrun`  out  1  one-`clk` pulse: good byte dropped because the output register was full.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, START, DATA, STOP. `cnt` (log2 OSR bits) and `bit_idx` (log2 DATA_BITS + 1 bits) change only on `baud_tick`.
- IDLE: on a tick with `rx_in=0`, go to START with `cnt=0`.
- START: on each tick, if `cnt==OSR/2-1` make a decision, otherwise `cnt++`.
  - Decision with `rx_in=0`: go to DATA with `cnt=0`, `bit_idx=0`.
  - Decision with `rx_in=1`: treat as a glitch and return to IDLE with no flags.
- DATA: on each tick, if `cnt==OSR-1` then:
  - shift `rx_in` into the MSB of `rx_data` (shift right, so LSB-first order lands correctly);
  - `bit_idx++` and `cnt=0`;
  - when `bit_idx` reaches DATA_BITS, go to STOP.
  - Otherwise `cnt++`.
- STOP: `check_stop=1`. On the tick with `cnt==OSR-1`, return to IDLE.
  - Good frame: `rx_in==1 && stop_err==0` → deliver `rx_data`.
  - Any other combination → pulse `frame_err`.
- Delivery:
  - If `!rx_valid` or `rx_ready` in the same cycle: load `rx_byte`, set `rx_valid=1`.
  - Otherwise: keep the old byte and pulse `overrun`.
- Handshake: `rx_valid` clears on `rx_valid && rx_ready` unless a new delivery happens that same cycle.
  - Simultaneous delivery and accept: `rx_valid` stays 1, `rx_byte` takes the new value, no `overrun`.
- Line held low after a frame error (break): IDLE restarts reception on the next tick; each such frame fails with `frame_err`.
- `baud_tick` absent: all counters and the state hold.

## Timing
- Reset values: state=IDLE, `cnt=0`, `bit_idx=0`, `rx_data=0`, `rx_byte=0`. Outputs `rx_valid`, `check_stop`, `frame_err`, `overrun`, `busy` are all 0.
- Reset mid-frame aborts immediately; no flag is raised and the partial byte is lost.
- Start decision: 8th tick after the detection tick. Each data sample: 16th tick of its bit. Stop sample: 16th tick of STOP. Total: 152 ticks from detection to the stop sample (OSR=16).
- `rx_valid`, `frame_err`, `overrun` are registered: they assert in the `clk` cycle after the stop-sampling tick.
- `check_stop` rises the `clk` after the last data sample and falls the `clk` after the stop sample.
- Earliest next start detection is the first tick after the return to IDLE. Back-to-back frames are supported.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP);
  - `UART_OSR=16` and `UART_DATA_BITS=8` default constants, shared with the stop-bit checker and TX.
- Sub-module `uart_tick_counter`: tick-gated modulo counter.
  - Ports: `clk`, `rst`, `baud_tick`, `clear`, `cnt`, `half` (`cnt==OSR/2-1`), `full` (`cnt==OSR-1`).
  - The FSM uses `half` in START and `full` in DATA/STOP.

## Test plan
- Clean frame 0xA5, `stop_err=0`, `rx_ready=1` → `rx_byte=0xA5`, `rx_valid` pulses for one `clk`, 152 ticks after detection.
- Start glitch (`rx_in` low for 4 ticks) → back to IDLE; no `rx_valid`, `frame_err` or `overrun`.
- Frame 0x3C with stop bit 0, then a second frame 0x3C with stop bit 1 but `stop_err=1` → `frame_err` pulses twice, `rx_valid` stays 0.
- Two frames 0x11 then 0x22 with `rx_ready=0` → `rx_byte=0x11`, `overrun` pulses once; raising `rx_ready` clears `rx_valid`.
- `rx_ready` asserted in the exact cycle a second byte 0x22 is delivered → `rx_byte=0x22`, `rx_valid=1`, no `overrun`.
- `rst` asserted at data bit 4 of a frame → all outputs 0 next `clk`; the following clean frame 0x5A is received correctly.
